// File: rtl/l2_pool_reader_if.sv
// Bus bundle for the layer-2 pooling reader.
// Groups the start/status handshake, the RAM read port and the pooled output stream.
//   start       : single-cycle request to pool the stored map
//   addr_rd     : RAM read address (driven by the reader)
//   din         : RAM read data, valid one cycle after addr_rd
//   dout        : pooled (max) value, signed
//   dout_valid  : one-cycle strobe qualifying dout/dout_idx
//   dout_idx    : pooled index, row-major
//   busy, done  : run status
// Modports: master = controller/RAM side, slave = reader.
interface l2_pool_reader_if #(
  parameter int unsigned DW = 18,
  parameter int unsigned AW = 7
);
  logic          start;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [4:0]    dout_idx;
  logic          busy;
  logic          done;

  modport master (
    output start, din,
    input  addr_rd, dout, dout_valid, dout_idx, busy, done
  );

  modport slave (
    input  start, din,
    output addr_rd, dout, dout_valid, dout_idx, busy, done
  );
endinterface

// File: rtl/l2_pool_reader.sv
// Read-side sequencer for the layer-2 feature-map RAM.
// Walks an IN_W x IN_W row-major map in non-overlapping 2x2 windows (stride 2), issuing one
// read address per cycle, and emits one signed max per window (OUT_W x OUT_W outputs).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : l2_pool_reader_if.slave (start, addr_rd, din, dout, dout_valid, dout_idx, busy, done)
module l2_pool_reader #(
  parameter int unsigned DW    = 18,
  parameter int unsigned AW    = 7,
  parameter int unsigned IN_W  = 11,
  parameter int unsigned OUT_W = 5
) (
  input logic              clk,
  input logic              rst,
  l2_pool_reader_if.slave  bus
);

  localparam int unsigned CW = $clog2(OUT_W);
  localparam logic [CW-1:0] PosLast = CW'(OUT_W - 1);
  localparam logic [4:0]    IdxLast = 5'(OUT_W * OUT_W - 1);
  // Base step from the last window of a pooled row to the first window of the next one.
  localparam logic [AW-1:0] RowStep = AW'(2 * IN_W - 2 * (OUT_W - 1));
  localparam logic [AW-1:0] ColStep = AW'(2);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e               state_q;
  logic [AW-1:0]        addr_q;
  logic [AW-1:0]        base_q;
  logic [1:0]           ph_q;      // window sample being addressed this cycle
  logic [CW-1:0]        pc_q;
  logic [CW-1:0]        pr_q;
  logic                 cap_vld_q; // din carries a window sample this cycle
  logic [1:0]           cap_ph_q;  // which sample din carries
  logic signed [DW-1:0] acc_q;
  logic [4:0]           out_cnt_q;
  logic [DW-1:0]        dout_q;
  logic                 dout_valid_q;
  logic [4:0]           dout_idx_q;
  logic                 busy_q;
  logic                 done_q;

  logic [AW-1:0]        off_next;
  logic signed [DW-1:0] din_s;
  logic                 din_gt;

  assign din_s  = bus.din;
  assign din_gt = din_s > acc_q;

  // Offset from the window base of the address following the current sample.
  always_comb begin
    off_next = '0;
    case (ph_q)
      2'd0:    off_next = AW'(1);
      2'd1:    off_next = AW'(IN_W);
      2'd2:    off_next = AW'(IN_W + 1);
      default: off_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      base_q       <= '0;
      ph_q         <= '0;
      pc_q         <= '0;
      pr_q         <= '0;
      cap_vld_q    <= 1'b0;
      cap_ph_q     <= '0;
      acc_q        <= '0;
      out_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_idx_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;

      // Capture side: one cycle behind the address side.
      cap_vld_q <= (state_q == StIssue);
      cap_ph_q  <= ph_q;
      if (cap_vld_q) begin
        case (cap_ph_q)
          2'd0: acc_q <= din_s;  // first sample loads unconditionally
          2'd1, 2'd2: begin
            if (din_gt) acc_q <= din_s;  // strict compare: ties keep the earlier sample
          end
          default: begin
            dout_q       <= din_gt ? bus.din : acc_q;
            dout_valid_q <= 1'b1;
            dout_idx_q   <= out_cnt_q;
            out_cnt_q    <= out_cnt_q + 5'd1;
            if (out_cnt_q == IdxLast) done_q <= 1'b1;
          end
        endcase
      end

      // Address side.
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StIssue;
            busy_q    <= 1'b1;
            addr_q    <= '0;
            base_q    <= '0;
            ph_q      <= '0;
            pc_q      <= '0;
            pr_q      <= '0;
            out_cnt_q <= '0;
          end
        end
        StIssue: begin
          if (ph_q == 2'd3) begin
            if (pc_q == PosLast && pr_q == PosLast) begin
              state_q <= StDrain;
            end else begin
              ph_q <= '0;
              if (pc_q == PosLast) begin
                pc_q   <= '0;
                pr_q   <= pr_q + CW'(1);
                base_q <= base_q + RowStep;
                addr_q <= base_q + RowStep;
              end else begin
                pc_q   <= pc_q + CW'(1);
                base_q <= base_q + ColStep;
                addr_q <= base_q + ColStep;
              end
            end
          end else begin
            ph_q   <= ph_q + 2'd1;
            addr_q <= base_q + off_next;
          end
        end
        StDrain: begin
          // Stay busy through the done cycle so a start there is ignored.
          if (done_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.addr_rd    = addr_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_idx   = dout_idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: doc/l2_pool_reader.md
Name: l2_pool_reader

Overview:
Read-side sequencer for the layer-2 feature-map RAM. It holds an 11x11 map of 18-bit signed activations at row-major addresses (addr = 11*row + col). On a start pulse the block walks the map in non-overlapping 2x2 windows with stride 2 and drives the RAM read address. It captures the registered read data and emits one signed max-pooled value per window, a 5x5 = 25-value output, to the next layer. The last row and last column (index 10) are not used.

Parameters:
DW, 18, data width of RAM words and pooled output (signed two's complement)
AW, 7, RAM address width
IN_W, 11, input map width and height
OUT_W, 5, pooled map width and height (= IN_W/2, floor); only the defaults are verified

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to pool the stored map; ignored while busy
addr_rd  output  AW  read address to the RAM
din  input  DW  RAM read data, valid one cycle after addr_rd is presented
dout  output  DW  pooled (max) value
dout_valid  output  1  one-cycle strobe, dout/dout_idx valid
dout_idx  output  5  pooled index 0..24 = OUT_W*pr + pc, row-major
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse coincident with the final dout_valid

Behaviour:
- Reset, and the idle state: addr_rd=0, dout=0, dout_valid=0, dout_idx=0, busy=0, done=0. The FSM goes to IDLE and all counters clear.
- FSM states: IDLE -> ISSUE, on start sampled high in IDLE. ISSUE -> DRAIN, after the 100th address. DRAIN -> IDLE, after the final output.
- start is accepted only in IDLE. start while busy, or in the done cycle, has no effect.
- Timing, with start sampled at cycle 0:
  - busy=1 from cycle 1.
  - Window k (0..24) issues its four addresses in cycles 4k+1..4k+4, one per cycle, with no bubbles.
  - Its data arrives on din in cycles 4k+2..4k+5.
  - Its result appears with dout_valid=1 in cycle 4k+6.
  - The last result and done appear in cycle 102. busy=0 and the FSM is in IDLE from cycle 103.
  - A new start is accepted from cycle 103.
- Window address order for pooled position (pr,pc): base = 22*pr + 2*pc, then base, base+1, base+11, base+12. Windows go in row-major order (pc fastest).
- Max rule:
  - The first sample of a window loads the accumulator unconditionally; it does not compare against a stale value.
  - Samples 2..4 replace the accumulator only if strictly greater (signed compare), so ties keep the earlier value.
  - No saturation and no ReLU is applied; negative maxima pass through unchanged.
- dout and dout_idx hold their last value when dout_valid=0. dout_valid never stays high for two consecutive cycles.
- Outside ISSUE, addr_rd holds its last issued value. Data on din outside the capture slots is ignored.
- rst high mid-run: at the next edge, return to the reset values above. No partial result and no done pulse is emitted.
- The block never writes the RAM. The system must not assert start until the layer-2 writer has finished. Concurrent writes during a run are not this block's concern; results are undefined.

Test Plan:
- Address trace: start at cycle 0 -> addr_rd in cycles 1..8 = 0,1,11,12,2,3,13,14; in cycles 97..100 = 96,97,107,108. busy 1..102, done at cycle 102 only.
- Ramp map, RAM[i]=i -> 25 outputs; dout(idx)=22*pr+2*pc+12, e.g. idx0=12, idx4=20, idx5=34, idx24=108, in strictly increasing idx order. dout_valid in cycles 6,10,...,102.
- Negative/tie data:
  - All words = -5 except RAM[13]=-2 -> idx1=-2, all others -5.
  - Window 0 = {7,7,-1,7} -> 7.
  - Word 0x20000 (most negative) mixed with 0 -> 0.
- Reset mid-run: rst high at cycle 40 -> next cycle all outputs zero, busy=0, no done. New start then gives the full correct 25-output sequence.
- Start handling: start pulses at cycles 5 and 102 are ignored (no restart, sequence unchanged). start at cycle 103 begins a second identical run.
- Idle stability: start never asserted for 200 cycles -> dout_valid, busy, done stay 0 and addr_rd stays 0.
